// File: rtl/srio_xfer_scheduler_if.sv
// ---------------------------------------------------------------------------
// srio_xfer_scheduler_if
// Groups the signals between the transfer scheduler, its command source and
// the SRIO initiator core.
//   cmd_*      : command handshake and fields (source -> scheduler)
//   ucfg_*     : initiator configuration and start pulses (scheduler -> core)
//   srio_*     : initiator busy status and doorbell response (core -> scheduler)
//   xfer_*     : completion / error pulses, sched_busy status
// Modports: slave = scheduler side, master = the environment driving it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface srio_xfer_scheduler_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_src_addr;
   logic [33:0] cmd_dest_addr;
   logic [15:0] cmd_len;
   logic [7:0]  cmd_dest_id;
   logic [15:0] cmd_db_info;
   logic        cmd_db_en;

   logic [7:0]  ucfg_dest_id;
   logic [31:0] ucfg_src_start_addr;
   logic [33:0] ucfg_dest_start_addr;
   logic [8:0]  ucfg_byte_count;
   logic [15:0] ucfg_db_info;
   logic        ucfg_wr_n;
   logic        ucfg_normal_trigger;
   logic        ucfg_db_trigger;

   logic        srio_initial_busy;
   logic        srio_db_resp;

   logic        xfer_done;
   logic        xfer_err;
   logic        sched_busy;

   modport slave (
      input  cmd_valid, cmd_src_addr, cmd_dest_addr, cmd_len, cmd_dest_id,
             cmd_db_info, cmd_db_en,
      output cmd_ready,
      output ucfg_dest_id, ucfg_src_start_addr, ucfg_dest_start_addr,
             ucfg_byte_count, ucfg_db_info, ucfg_wr_n,
             ucfg_normal_trigger, ucfg_db_trigger,
      input  srio_initial_busy, srio_db_resp,
      output xfer_done, xfer_err, sched_busy
   );

   modport master (
      output cmd_valid, cmd_src_addr, cmd_dest_addr, cmd_len, cmd_dest_id,
             cmd_db_info, cmd_db_en,
      input  cmd_ready,
      input  ucfg_dest_id, ucfg_src_start_addr, ucfg_dest_start_addr,
             ucfg_byte_count, ucfg_db_info, ucfg_wr_n,
             ucfg_normal_trigger, ucfg_db_trigger,
      output srio_initial_busy, srio_db_resp,
      input  xfer_done, xfer_err, sched_busy
   );
endinterface

// File: rtl/srio_xfer_scheduler.sv
// ---------------------------------------------------------------------------
// srio_xfer_scheduler
// Splits a local->remote copy command into SWRITE packets of at most MAX_PKT
// bytes, drives the SRIO initiator for each one, optionally follows up with a
// doorbell and reports completion (xfer_done) or doorbell timeout (xfer_err).
// Ports:
//   sys_clk    : clock
//   sys_rst_n  : asynchronous active-low reset
//   sched_if   : srio_xfer_scheduler_if.slave (command, initiator, status)
// Parameters:
//   MAX_PKT    : max payload bytes per SWRITE packet (power of 2, 8..256)
//   DB_TIMEOUT : cycles to wait in DB_RESP for a doorbell response
// All outputs are registered; output registers are loaded from the
// next-state value so a pulse lines up with the cycle its state is active.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module srio_xfer_scheduler #(
   parameter int MAX_PKT    = 256,
   parameter int DB_TIMEOUT = 65535
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   srio_xfer_scheduler_if.slave   sched_if
);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_SEG_ISSUE = 4'd1,
      ST_SEG_GUARD = 4'd2,
      ST_SEG_WAIT  = 4'd3,
      ST_DB_ISSUE  = 4'd4,
      ST_DB_GUARD  = 4'd5,
      ST_DB_WAIT   = 4'd6,
      ST_DB_RESP   = 4'd7,
      ST_DONE      = 4'd8
   } state_t;

   localparam logic [15:0] MAX_PKT_LEN  = 16'(MAX_PKT);
   localparam logic [31:0] DB_TIMEOUT_C = 32'(DB_TIMEOUT);

   state_t      r_state, w_state_nxt;

   logic [15:0] r_rem_len, w_rem_nxt;
   logic [31:0] r_src_ptr, w_src_nxt;
   logic [33:0] r_dst_ptr, w_dst_nxt;
   logic [15:0] r_chunk;
   logic [15:0] w_chunk_nxt;
   logic [7:0]  r_dest_id, w_dest_id_nxt;
   logic [15:0] r_db_info, w_db_info_nxt;
   logic        r_db_en, w_db_en_nxt;
   logic        r_guard, w_guard_nxt;
   logic        r_db_sticky, w_sticky_nxt;
   logic [31:0] r_db_cnt, w_cnt_nxt;
   logic [31:0] w_cnt_inc;
   logic        w_err_nxt;
   logic [15:0] w_len_clean;

   logic        r_cmd_ready;
   logic        r_sched_busy;
   logic        r_normal_trig;
   logic        r_db_trig;
   logic        r_xfer_done;
   logic        r_xfer_err;
   logic [7:0]  r_ucfg_dest_id;
   logic [31:0] r_ucfg_src;
   logic [33:0] r_ucfg_dst;
   logic [8:0]  r_ucfg_byte_count;
   logic [15:0] r_ucfg_db_info;
   logic        r_ucfg_wr_n;

   // Low three length bits are dropped: transfers are whole 8-byte beats.
   logic w_unused;
   assign w_unused    = &{1'b0, sched_if.cmd_len[2:0]};
   assign w_len_clean = {sched_if.cmd_len[15:3], 3'b000};
   assign w_cnt_inc   = r_db_cnt + 32'd1;

   // Packet size for the next SEG_ISSUE, derived from the post-update length.
   assign w_chunk_nxt = (w_rem_nxt > MAX_PKT_LEN) ? MAX_PKT_LEN : w_rem_nxt;

   // State register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath-update logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_rem_nxt     = r_rem_len;
      w_src_nxt     = r_src_ptr;
      w_dst_nxt     = r_dst_ptr;
      w_dest_id_nxt = r_dest_id;
      w_db_info_nxt = r_db_info;
      w_db_en_nxt   = r_db_en;
      w_guard_nxt   = 1'b0;
      w_sticky_nxt  = r_db_sticky;
      w_cnt_nxt     = r_db_cnt;
      w_err_nxt     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (sched_if.cmd_valid) begin
               w_rem_nxt     = w_len_clean;
               w_src_nxt     = sched_if.cmd_src_addr;
               w_dst_nxt     = sched_if.cmd_dest_addr;
               w_dest_id_nxt = sched_if.cmd_dest_id;
               w_db_info_nxt = sched_if.cmd_db_info;
               w_db_en_nxt   = sched_if.cmd_db_en;
               if (w_len_clean != 16'd0) begin
                  w_state_nxt = ST_SEG_ISSUE;
               end else if (sched_if.cmd_db_en) begin
                  w_state_nxt = ST_DB_ISSUE;
               end else begin
                  w_state_nxt = ST_DONE;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SEG_ISSUE: begin
            w_state_nxt = ST_SEG_GUARD;
         end
         ST_SEG_GUARD: begin
            // The initiator raises busy a cycle after the trigger, so busy
            // is not trusted for two cycles.
            if (r_guard) begin
               w_state_nxt = ST_SEG_WAIT;
            end else begin
               w_guard_nxt = 1'b1;
            end
         end
         ST_SEG_WAIT: begin
            if (!sched_if.srio_initial_busy) begin
               w_rem_nxt = (r_rem_len > r_chunk) ? (r_rem_len - r_chunk) : 16'd0;
               w_src_nxt = r_src_ptr + {16'd0, r_chunk};
               w_dst_nxt = r_dst_ptr + {18'd0, r_chunk};
               if (w_rem_nxt != 16'd0) begin
                  w_state_nxt = ST_SEG_ISSUE;
               end else if (r_db_en) begin
                  w_state_nxt = ST_DB_ISSUE;
               end else begin
                  w_state_nxt = ST_DONE;
               end
            end else begin
               w_state_nxt = ST_SEG_WAIT;
            end
         end
         ST_DB_ISSUE: begin
            w_sticky_nxt = 1'b0;
            w_state_nxt  = ST_DB_GUARD;
         end
         ST_DB_GUARD: begin
            // A fast response may beat DB_RESP; remember it.
            if (sched_if.srio_db_resp) begin
               w_sticky_nxt = 1'b1;
            end else begin
               w_sticky_nxt = r_db_sticky;
            end
            if (r_guard) begin
               w_state_nxt = ST_DB_WAIT;
            end else begin
               w_guard_nxt = 1'b1;
            end
         end
         ST_DB_WAIT: begin
            if (sched_if.srio_db_resp) begin
               w_sticky_nxt = 1'b1;
            end else begin
               w_sticky_nxt = r_db_sticky;
            end
            if (!sched_if.srio_initial_busy) begin
               w_cnt_nxt   = 32'd0;
               w_state_nxt = ST_DB_RESP;
            end else begin
               w_state_nxt = ST_DB_WAIT;
            end
         end
         ST_DB_RESP: begin
            if (sched_if.srio_db_resp || r_db_sticky) begin
               w_state_nxt = ST_DONE;
            end else if (w_cnt_inc >= DB_TIMEOUT_C) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_rem_len         <= 16'd0;
         r_src_ptr         <= 32'd0;
         r_dst_ptr         <= 34'd0;
         r_chunk           <= 16'd0;
         r_dest_id         <= 8'd0;
         r_db_info         <= 16'd0;
         r_db_en           <= 1'b0;
         r_guard           <= 1'b0;
         r_db_sticky       <= 1'b0;
         r_db_cnt          <= 32'd0;
         r_cmd_ready       <= 1'b1;
         r_sched_busy      <= 1'b0;
         r_normal_trig     <= 1'b0;
         r_db_trig         <= 1'b0;
         r_xfer_done       <= 1'b0;
         r_xfer_err        <= 1'b0;
         r_ucfg_dest_id    <= 8'd0;
         r_ucfg_src        <= 32'd0;
         r_ucfg_dst        <= 34'd0;
         r_ucfg_byte_count <= 9'd0;
         r_ucfg_db_info    <= 16'd0;
         r_ucfg_wr_n       <= 1'b0;
      end else begin
         r_rem_len     <= w_rem_nxt;
         r_src_ptr     <= w_src_nxt;
         r_dst_ptr     <= w_dst_nxt;
         r_dest_id     <= w_dest_id_nxt;
         r_db_info     <= w_db_info_nxt;
         r_db_en       <= w_db_en_nxt;
         r_guard       <= w_guard_nxt;
         r_db_sticky   <= w_sticky_nxt;
         r_db_cnt      <= w_cnt_nxt;
         r_cmd_ready   <= (w_state_nxt == ST_IDLE);
         r_sched_busy  <= (w_state_nxt != ST_IDLE);
         r_normal_trig <= (w_state_nxt == ST_SEG_ISSUE);
         r_db_trig     <= (w_state_nxt == ST_DB_ISSUE);
         r_xfer_done   <= (w_state_nxt == ST_DONE);
         r_xfer_err    <= w_err_nxt;
         // Configuration only changes on entry to an ISSUE state, so it is
         // stable for the whole packet/doorbell.
         if (w_state_nxt == ST_SEG_ISSUE) begin
            r_chunk           <= w_chunk_nxt;
            r_ucfg_byte_count <= w_chunk_nxt[8:0];
            r_ucfg_src        <= w_src_nxt;
            r_ucfg_dst        <= w_dst_nxt;
            r_ucfg_dest_id    <= w_dest_id_nxt;
            r_ucfg_wr_n       <= 1'b0;
         end
         if (w_state_nxt == ST_DB_ISSUE) begin
            r_ucfg_db_info <= w_db_info_nxt;
            r_ucfg_dest_id <= w_dest_id_nxt;
         end
      end
   end

   assign sched_if.cmd_ready            = r_cmd_ready;
   assign sched_if.sched_busy           = r_sched_busy;
   assign sched_if.ucfg_normal_trigger  = r_normal_trig;
   assign sched_if.ucfg_db_trigger      = r_db_trig;
   assign sched_if.xfer_done            = r_xfer_done;
   assign sched_if.xfer_err             = r_xfer_err;
   assign sched_if.ucfg_dest_id         = r_ucfg_dest_id;
   assign sched_if.ucfg_src_start_addr  = r_ucfg_src;
   assign sched_if.ucfg_dest_start_addr = r_ucfg_dst;
   assign sched_if.ucfg_byte_count      = r_ucfg_byte_count;
   assign sched_if.ucfg_db_info         = r_ucfg_db_info;
   assign sched_if.ucfg_wr_n            = r_ucfg_wr_n;

endmodule

// File: tb/tb_srio_xfer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_srio_xfer_scheduler
// Directed bench for srio_xfer_scheduler. Each command pushes its expected
// initiator triggers and its expected completion into scoreboard queues; a
// negedge monitor pops and compares them as the DUT produces them. A small
// behavioural initiator raises busy after each trigger and answers doorbells.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_srio_xfer_scheduler;
   localparam int MAX_PKT = 256;
   localparam int DB_TO   = 40;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;
   always #5 sys_clk = ~sys_clk;

   srio_xfer_scheduler_if u_if();

   srio_xfer_scheduler #(.MAX_PKT(MAX_PKT), .DB_TIMEOUT(DB_TO)) u_dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .sched_if  (u_if.slave)
   );

   typedef struct {
      bit          db;
      logic [8:0]  bc;
      logic [31:0] src;
      logic [33:0] dst;
      logic [15:0] info;
      logic [7:0]  id;
   } exp_t;

   exp_t       exp_q[$];
   logic [1:0] done_q[$];   // 2'b01 = xfer_done, 2'b10 = xfer_err

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- initiator model ----------------
   int busy_len   = 5;
   int resp_mode  = 0;   // 0 none, 1 after busy falls + resp_delay, 2 during guard
   int resp_delay = 10;
   int bcnt = 0, rcnt = 0;
   bit db_pend = 0;
   bit seen_norm = 0, seen_db = 0;

   always @(posedge sys_clk) begin
      #1;
      u_if.srio_db_resp = 1'b0;
      if (!sys_rst_n) begin
         u_if.srio_initial_busy = 1'b0;
         bcnt = 0; rcnt = 0; db_pend = 0;
      end else if (seen_norm || seen_db) begin
         bcnt = busy_len;
         u_if.srio_initial_busy = 1'b1;
         db_pend = seen_db && (resp_mode == 1);
         if (seen_db && resp_mode == 2) u_if.srio_db_resp = 1'b1;
      end else if (bcnt > 0) begin
         bcnt--;
         if (bcnt == 0) begin
            u_if.srio_initial_busy = 1'b0;
            if (db_pend) begin rcnt = resp_delay; db_pend = 0; end
         end
      end else if (rcnt > 0) begin
         rcnt--;
         if (rcnt == 0) u_if.srio_db_resp = 1'b1;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int   cyc = 0;
   int   last_db_cyc = 0;
   bit   chk_ready_next = 0;
   exp_t m_e;
   logic [1:0] m_k;

   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         seen_norm = 0; seen_db = 0; chk_ready_next = 0;
      end else begin
         cyc++;
         seen_norm = u_if.ucfg_normal_trigger;
         seen_db   = u_if.ucfg_db_trigger;
         if (chk_ready_next) begin
            chk("ready_after_err", u_if.cmd_ready, 1'b1);
            chk_ready_next = 0;
         end
         if (seen_norm || seen_db) begin
            chk("trig_exclusive", seen_norm & seen_db, 1'b0);
            chk("trig_while_busy", u_if.srio_initial_busy, 1'b0);
            chk("trig_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               m_e = exp_q.pop_front();
               chk("trig_kind", seen_db, m_e.db);
               if (m_e.db) begin
                  chk("db_info", u_if.ucfg_db_info, m_e.info);
                  chk("db_dest_id", u_if.ucfg_dest_id, m_e.id);
                  last_db_cyc = cyc;
               end else begin
                  chk("seg_byte_count", u_if.ucfg_byte_count, m_e.bc);
                  chk("seg_src", u_if.ucfg_src_start_addr, m_e.src);
                  chk("seg_dst", u_if.ucfg_dest_start_addr, m_e.dst);
                  chk("seg_dest_id", u_if.ucfg_dest_id, m_e.id);
                  chk("seg_wr_n", u_if.ucfg_wr_n, 1'b0);
               end
            end
         end
         if (u_if.xfer_done || u_if.xfer_err) begin
            chk("completion_expected", done_q.size() > 0, 1'b1);
            if (done_q.size() > 0) begin
               m_k = done_q.pop_front();
               chk("completion_kind", {u_if.xfer_err, u_if.xfer_done}, m_k);
            end
            if (u_if.xfer_err) begin
               // guard 2 + busy window + DB_TIMEOUT cycles spent in DB_RESP
               chk("err_latency", cyc - last_db_cyc, busy_len + 2 + DB_TO);
               chk_ready_next = 1;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_cmd(input logic [31:0] src, input logic [33:0] dst,
                           input logic [15:0] len, input logic [7:0] id,
                           input logic [15:0] info, input bit db_en);
      logic [15:0] rem, ch;
      logic [31:0] s;
      logic [33:0] d;
      exp_t x;
      @(negedge sys_clk);
      chk("cmd_ready_idle", u_if.cmd_ready, 1'b1);
      u_if.cmd_src_addr  = src;
      u_if.cmd_dest_addr = dst;
      u_if.cmd_len       = len;
      u_if.cmd_dest_id   = id;
      u_if.cmd_db_info   = info;
      u_if.cmd_db_en     = db_en;
      u_if.cmd_valid     = 1'b1;
      rem = len & 16'hFFF8;
      s = src;
      d = dst;
      while (rem != 16'd0) begin
         ch = (int'(rem) > MAX_PKT) ? 16'(MAX_PKT) : rem;
         x.db = 0; x.bc = ch[8:0]; x.src = s; x.dst = d; x.info = 16'd0; x.id = id;
         exp_q.push_back(x);
         rem = rem - ch;
         s = s + {16'd0, ch};
         d = d + {18'd0, ch};
      end
      if (db_en) begin
         x.db = 1; x.bc = 9'd0; x.src = 32'd0; x.dst = 34'd0; x.info = info; x.id = id;
         exp_q.push_back(x);
      end
      done_q.push_back((db_en && resp_mode == 0) ? 2'b10 : 2'b01);
      @(posedge sys_clk);
      #1;
      u_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_complete(input string tag, input int budget);
      int n = 0;
      while (done_q.size() != 0 && n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      chk({tag, "_completion_timeout"}, done_q.size(), 0);
      chk({tag, "_triggers_left"}, exp_q.size(), 0);
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, u_if.cmd_ready, 1'b1);
      chk({tag, "_sched_busy"}, u_if.sched_busy, 1'b0);
      chk({tag, "_norm_trig"}, u_if.ucfg_normal_trigger, 1'b0);
      chk({tag, "_db_trig"}, u_if.ucfg_db_trigger, 1'b0);
      chk({tag, "_byte_count"}, u_if.ucfg_byte_count, 9'd0);
      chk({tag, "_src"}, u_if.ucfg_src_start_addr, 32'd0);
      chk({tag, "_dst"}, u_if.ucfg_dest_start_addr, 34'd0);
      chk({tag, "_db_info"}, u_if.ucfg_db_info, 16'd0);
      chk({tag, "_dest_id"}, u_if.ucfg_dest_id, 8'd0);
      chk({tag, "_wr_n"}, u_if.ucfg_wr_n, 1'b0);
      chk({tag, "_done"}, u_if.xfer_done, 1'b0);
      chk({tag, "_err"}, u_if.xfer_err, 1'b0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      u_if.cmd_valid     = 1'b0;
      u_if.cmd_src_addr  = 32'd0;
      u_if.cmd_dest_addr = 34'd0;
      u_if.cmd_len       = 16'd0;
      u_if.cmd_dest_id   = 8'd0;
      u_if.cmd_db_info   = 16'd0;
      u_if.cmd_db_en     = 1'b0;

      repeat (3) @(negedge sys_clk);
      check_reset_outputs("reset");
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      check_reset_outputs("post_reset");

      // 64 bytes, no doorbell; a stray cmd_valid mid-transfer must be ignored
      resp_mode = 0;
      send_cmd(32'h0000_0100, 34'h0_0000_0200, 16'd64, 8'h11, 16'h0000, 1'b0);
      repeat (3) @(negedge sys_clk);
      chk("ready_low_busy", u_if.cmd_ready, 1'b0);
      chk("sched_busy_high", u_if.sched_busy, 1'b1);
      u_if.cmd_len   = 16'd512;
      u_if.cmd_valid = 1'b1;
      @(negedge sys_clk);
      u_if.cmd_valid = 1'b0;
      wait_complete("len64", 300);

      // 600 bytes -> 256/256/88
      send_cmd(32'h0000_1000, 34'h2_0000_0000, 16'd600, 8'h22, 16'h0000, 1'b0);
      wait_complete("len600", 500);

      // doorbell only, response 10 cycles after busy falls
      resp_mode = 1;
      send_cmd(32'h0, 34'h0, 16'd0, 8'h33, 16'hBEEF, 1'b1);
      wait_complete("db_only", 300);

      // doorbell never answered -> xfer_err
      resp_mode = 0;
      send_cmd(32'h0000_4000, 34'h1_0000_4000, 16'd16, 8'h44, 16'h1234, 1'b1);
      wait_complete("db_timeout", 400);

      // response arrives during DB_GUARD
      resp_mode = 2;
      send_cmd(32'h0, 34'h0, 16'd0, 8'h55, 16'hCAFE, 1'b1);
      wait_complete("db_guard_resp", 300);

      // pointer wrap, low length bits ignored (0x20F -> 520 bytes)
      resp_mode = 0;
      send_cmd(32'hFFFF_FF80, 34'h3_FFFF_FF80, 16'h020F, 8'h66, 16'h0000, 1'b0);
      wait_complete("wrap", 500);

      // reset during SEG_WAIT of a 600-byte transfer
      send_cmd(32'h0000_1000, 34'h2_0000_0000, 16'd600, 8'h77, 16'h0000, 1'b0);
      begin
         int n = 0;
         while (exp_q.size() > 1 && n < 200) begin
            @(negedge sys_clk);
            n++;
         end
      end
      chk("second_seg_seen", exp_q.size(), 1);
      repeat (4) @(negedge sys_clk);
      chk("mid_xfer_busy", u_if.sched_busy, 1'b1);
      #2;
      sys_rst_n = 1'b0;
      exp_q.delete();
      done_q.delete();
      #1;
      check_reset_outputs("mid_reset");
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (6) @(negedge sys_clk);
      chk("idle_after_reset", u_if.sched_busy, 1'b0);
      send_cmd(32'h0000_8000, 34'h0_0000_9000, 16'd8, 8'h88, 16'h0000, 1'b0);
      wait_complete("after_reset_len8", 300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
